// File: rtl/frame_store_pkg.sv
// rtl/frame_store_pkg.sv - shared types and sizing helpers for the frame store
package frame_store_pkg;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam int FRAMEW = 128;

    // One RAM slot stays unused so that wp==rp always means "RAM empty".
    function automatic int maxCnt(input int log2Depth);
        return (1 << log2Depth) - 1;
    endfunction

endpackage

// File: rtl/frame_store_ctrl_if.sv
// rtl/frame_store_ctrl_if.sv - assembler write side and packer head-frame side
interface frame_store_ctrl_if #(
    parameter int BUFFLENLOG2 = 9
);
    import frame_store_pkg::*;

    logic [FRAMEW-1:0]      WrFrame;
    logic                   WrValid;
    logic [FRAMEW-1:0]      Frame;
    logic                   FrameReady;
    logic                   FrameNext;
    logic [BUFFLENLOG2-1:0] FramesCnt;

    modport master (
        output WrFrame, WrValid, FrameNext,
        input  Frame, FrameReady, FramesCnt
    );

    modport slave (
        input  WrFrame, WrValid, FrameNext,
        output Frame, FrameReady, FramesCnt
    );

endinterface

// File: rtl/frame_ram.sv
// rtl/frame_ram.sv - simple dual-port RAM, one write port, registered read port
module frame_ram #(
    parameter int AW = 9,
    parameter int DW = 128
) (
    input  logic          clk,
    input  logic          wrEn,
    input  logic [AW-1:0] wrAddr,
    input  logic [DW-1:0] wrData,
    input  logic          rdEn,
    input  logic [AW-1:0] rdAddr,
    output logic [DW-1:0] rdData
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // No reset on storage or read register so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
        if (rdEn) begin
            rdData <= mem[rdAddr];
        end
    end

endmodule

// File: rtl/frame_store_ctrl.sv
// rtl/frame_store_ctrl.sv - circular trace-frame store with a pre-fetched head
// register feeding the SPI packer, plus drop statistics.
module frame_store_ctrl
    import frame_store_pkg::*;
#(
    parameter int BUFFLENLOG2 = 9,
    parameter int LOSTW       = 16
) (
    input  logic             clk,
    input  logic             rst,
    frame_store_ctrl_if.slave bus,
    input  logic             Flush,
    input  logic             ClrStats,
    output logic             Overflow,
    output logic [LOSTW-1:0] LostCnt
);

    localparam logic [BUFFLENLOG2-1:0] MAXCNT  = BUFFLENLOG2'(maxCnt(BUFFLENLOG2));
    localparam logic [BUFFLENLOG2-1:0] PTR_ONE = BUFFLENLOG2'(1);
    localparam logic [LOSTW-1:0]       LOST_ONE = LOSTW'(1);

    state_t                 state;
    logic [BUFFLENLOG2-1:0] wp;
    logic [BUFFLENLOG2-1:0] rp;
    logic [BUFFLENLOG2-1:0] cnt;
    logic [FRAMEW-1:0]      frameReg;
    logic                   readyReg;
    logic [FRAMEW-1:0]      ramData;

    logic ramEmpty;
    logic consume;
    logic wrAccept;
    logic drop;
    logic rdIssue;

    // Space is judged on the registered count, so a same-cycle consume
    // never makes room for the write arriving with it.
    assign ramEmpty = (wp == rp);
    assign consume  = bus.FrameNext && (state == S_HOLD) && !Flush;
    assign wrAccept = bus.WrValid && !Flush && (cnt != MAXCNT);
    assign drop     = bus.WrValid && !Flush && (cnt == MAXCNT);
    assign rdIssue  = !Flush && !ramEmpty && ((state == S_EMPTY) || consume);

    frame_ram #(
        .AW (BUFFLENLOG2),
        .DW (FRAMEW)
    ) u_ram (
        .clk    (clk),
        .wrEn   (wrAccept),
        .wrAddr (wp),
        .wrData (bus.WrFrame),
        .rdEn   (rdIssue),
        .rdAddr (rp),
        .rdData (ramData)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_EMPTY;
            wp       <= '0;
            rp       <= '0;
            cnt      <= '0;
            frameReg <= '0;
            readyReg <= 1'b0;
        end else if (Flush) begin
            // An outstanding read simply lands in the RAM output register unused.
            state    <= S_EMPTY;
            wp       <= '0;
            rp       <= '0;
            cnt      <= '0;
            readyReg <= 1'b0;
        end else begin
            if (wrAccept) begin
                wp <= wp + PTR_ONE;
            end
            if (rdIssue) begin
                rp <= rp + PTR_ONE;
            end

            case ({wrAccept, consume})
                2'b10:   cnt <= cnt + PTR_ONE;
                2'b01:   cnt <= cnt - PTR_ONE;
                default: cnt <= cnt;
            endcase

            case (state)
                S_EMPTY: begin
                    if (!ramEmpty) begin
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    frameReg <= ramData;
                    readyReg <= 1'b1;
                    state    <= S_HOLD;
                end
                S_HOLD: begin
                    if (consume) begin
                        readyReg <= 1'b0;
                        state    <= ramEmpty ? S_EMPTY : S_FETCH;
                    end
                end
                default: begin
                    state    <= S_EMPTY;
                    readyReg <= 1'b0;
                end
            endcase
        end
    end

    // A drop coinciding with a clear restarts the statistics at one drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Overflow <= 1'b0;
            LostCnt  <= '0;
        end else if (drop) begin
            Overflow <= 1'b1;
            if (ClrStats) begin
                LostCnt <= LOST_ONE;
            end else if (LostCnt != '1) begin
                LostCnt <= LostCnt + LOST_ONE;
            end
        end else if (ClrStats) begin
            Overflow <= 1'b0;
            LostCnt  <= '0;
        end
    end

    assign bus.Frame      = frameReg;
    assign bus.FrameReady = readyReg;
    assign bus.FramesCnt  = cnt;

endmodule

// File: tb/tb_frame_store_ctrl.sv
// tb/tb_frame_store_ctrl.sv - directed bench for frame_store_ctrl, two
// instances sharing stimulus (16-bit and 2-bit lost counters).
module tb_frame_store_ctrl;
    import frame_store_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [127:0] wrFrame   = '0;
    logic         wrValid   = 1'b0;
    logic         frameNext = 1'b0;
    logic         flush     = 1'b0;
    logic         clrStats  = 1'b0;

    logic         ovfA, ovfS;
    logic [15:0]  lostA;
    logic [1:0]   lostS;

    frame_store_ctrl_if #(.BUFFLENLOG2(4)) ifA ();
    frame_store_ctrl_if #(.BUFFLENLOG2(4)) ifS ();

    assign ifA.WrFrame   = wrFrame;
    assign ifA.WrValid   = wrValid;
    assign ifA.FrameNext = frameNext;
    assign ifS.WrFrame   = wrFrame;
    assign ifS.WrValid   = wrValid;
    assign ifS.FrameNext = frameNext;

    frame_store_ctrl #(.BUFFLENLOG2(4), .LOSTW(16)) dutA (
        .clk      (clk),
        .rst      (rst),
        .bus      (ifA),
        .Flush    (flush),
        .ClrStats (clrStats),
        .Overflow (ovfA),
        .LostCnt  (lostA)
    );

    frame_store_ctrl #(.BUFFLENLOG2(4), .LOSTW(2)) dutS (
        .clk      (clk),
        .rst      (rst),
        .bus      (ifS),
        .Flush    (flush),
        .ClrStats (clrStats),
        .Overflow (ovfS),
        .LostCnt  (lostS)
    );

    int nCmp = 0;
    int nErr = 0;

    task automatic checkVal(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nCmp++;
        if (obs !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] mk(input int i);
        return {32'hF00D_0000 | 32'(i), 64'h0123_4567_89AB_CDEF, 32'(i)};
    endfunction

    task automatic writeN(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            wrValid = 1'b1;
            wrFrame = mk(base + i);
            cyc();
        end
        wrValid = 1'b0;
    endtask

    task automatic waitReady(input string tag);
        int w = 0;
        while (!ifA.FrameReady && w < 8) begin
            cyc();
            w++;
        end
        checkVal(tag, ifA.FrameReady, 1'b1);
    endtask

    initial begin
        int j;
        int k;
        int budget;
        int maxC;

        // Reset state
        cyc();
        cyc();
        checkVal("rst_frame", ifA.Frame, 128'h0);
        checkVal("rst_ready", ifA.FrameReady, 1'b0);
        checkVal("rst_cnt", ifA.FramesCnt, 4'd0);
        checkVal("rst_ovf", ovfA, 1'b0);
        checkVal("rst_lost", lostA, 16'd0);
        checkVal("rst_state", dutA.state, S_EMPTY);
        rst = 1'b0;
        cyc();

        // Single frame into empty store: ready two edges after the write edge
        wrValid = 1'b1;
        wrFrame = 128'h0123456789ABCDEF0123456789ABCDEF;
        cyc();
        wrValid = 1'b0;
        checkVal("single_cnt", ifA.FramesCnt, 4'd1);
        checkVal("single_ready_e0", ifA.FrameReady, 1'b0);
        cyc();
        checkVal("single_ready_e1", ifA.FrameReady, 1'b0);
        cyc();
        checkVal("single_ready_e2", ifA.FrameReady, 1'b1);
        checkVal("single_frame", ifA.Frame, 128'h0123456789ABCDEF0123456789ABCDEF);
        frameNext = 1'b1;
        cyc();
        frameNext = 1'b0;
        checkVal("single_ready_off", ifA.FrameReady, 1'b0);
        checkVal("single_cnt_0", ifA.FramesCnt, 4'd0);
        checkVal("single_state", dutA.state, S_EMPTY);

        // Overflow: 20 writes into 15 slots, then drain in order
        writeN(0, 20);
        cyc();
        checkVal("ovf_cnt", ifA.FramesCnt, 4'd15);
        checkVal("ovf_flag", ovfA, 1'b1);
        checkVal("ovf_lost", lostA, 16'd5);
        checkVal("ovf_lost_sat", lostS, 2'd3);
        checkVal("ovf_flag_s", ovfS, 1'b1);
        for (int i = 0; i < 15; i++) begin
            waitReady("drain_ready");
            checkVal("drain_data", ifA.Frame, mk(i));
            frameNext = 1'b1;
            cyc();
            frameNext = 1'b0;
        end
        cyc();
        checkVal("drain_cnt", ifA.FramesCnt, 4'd0);
        checkVal("drain_ready_off", ifA.FrameReady, 1'b0);

        // Streaming past three pointer wraps: one write per consume
        wrValid = 1'b1;
        wrFrame = mk(100);
        cyc();
        wrValid = 1'b0;
        j = 0;
        k = 1;
        budget = 0;
        maxC = 0;
        while (j < 56 && budget < 400) begin
            if (ifA.FrameReady) begin
                checkVal("stream_data", ifA.Frame, mk(100 + j));
                j++;
                frameNext = 1'b1;
                if (k < 56) begin
                    wrValid = 1'b1;
                    wrFrame = mk(100 + k);
                    k++;
                end else begin
                    wrValid = 1'b0;
                end
            end else begin
                frameNext = 1'b0;
                wrValid   = 1'b0;
            end
            cyc();
            if (int'(ifA.FramesCnt) > maxC) maxC = int'(ifA.FramesCnt);
            budget++;
        end
        frameNext = 1'b0;
        wrValid   = 1'b0;
        cyc();
        checkVal("stream_done", j, 56);
        checkVal("stream_max_le2", (maxC <= 2), 1'b1);
        checkVal("stream_cnt_end", ifA.FramesCnt, 4'd0);
        checkVal("stream_no_loss", lostA, 16'd5);

        // Same-cycle write and consume keeps the count
        writeN(200, 5);
        cyc();
        cyc();
        checkVal("same_pre_cnt", ifA.FramesCnt, 4'd5);
        checkVal("same_pre_ready", ifA.FrameReady, 1'b1);
        wrValid   = 1'b1;
        wrFrame   = mk(205);
        frameNext = 1'b1;
        cyc();
        wrValid   = 1'b0;
        frameNext = 1'b0;
        checkVal("same_cnt", ifA.FramesCnt, 4'd5);

        // Flush with count 7 and a simultaneous write and consume
        writeN(206, 2);
        cyc();
        cyc();
        checkVal("flush_pre_cnt", ifA.FramesCnt, 4'd7);
        flush     = 1'b1;
        wrValid   = 1'b1;
        wrFrame   = mk(999);
        frameNext = 1'b1;
        cyc();
        flush     = 1'b0;
        wrValid   = 1'b0;
        frameNext = 1'b0;
        checkVal("flush_cnt", ifA.FramesCnt, 4'd0);
        checkVal("flush_ready", ifA.FrameReady, 1'b0);
        checkVal("flush_lost", lostA, 16'd5);
        checkVal("flush_state", dutA.state, S_EMPTY);
        writeN(300, 1);
        checkVal("flush_w_e0", ifA.FrameReady, 1'b0);
        cyc();
        checkVal("flush_w_e1", ifA.FrameReady, 1'b0);
        cyc();
        checkVal("flush_w_e2", ifA.FrameReady, 1'b1);
        checkVal("flush_w_data", ifA.Frame, mk(300));
        frameNext = 1'b1;
        cyc();
        frameNext = 1'b0;
        checkVal("flush_w_cnt", ifA.FramesCnt, 4'd0);

        // Statistics: clear, saturate, clear colliding with a drop
        clrStats = 1'b1;
        cyc();
        clrStats = 1'b0;
        checkVal("clr_ovf", ovfA, 1'b0);
        checkVal("clr_lost", lostA, 16'd0);
        checkVal("clr_lost_s", lostS, 2'd0);
        writeN(400, 21);
        checkVal("sat_lost_a", lostA, 16'd6);
        checkVal("sat_lost_s", lostS, 2'd3);
        clrStats = 1'b1;
        wrValid  = 1'b1;
        wrFrame  = mk(450);
        cyc();
        clrStats = 1'b0;
        wrValid  = 1'b0;
        checkVal("clrdrop_ovf", ovfA, 1'b1);
        checkVal("clrdrop_lost", lostA, 16'd1);
        checkVal("clrdrop_ovf_s", ovfS, 1'b1);
        checkVal("clrdrop_lost_s", lostS, 2'd1);

        // Asynchronous reset while a fetch is in flight
        waitReady("prefetch_ready");
        frameNext = 1'b1;
        cyc();
        frameNext = 1'b0;
        checkVal("fetch_state", dutA.state, S_FETCH);
        rst = 1'b1;
        #1;
        checkVal("arst_frame", ifA.Frame, 128'h0);
        checkVal("arst_ready", ifA.FrameReady, 1'b0);
        checkVal("arst_cnt", ifA.FramesCnt, 4'd0);
        checkVal("arst_ovf", ovfA, 1'b0);
        checkVal("arst_lost", lostA, 16'd0);
        checkVal("arst_state", dutA.state, S_EMPTY);
        cyc();
        rst = 1'b0;
        cyc();
        writeN(500, 1);
        cyc();
        checkVal("post_rst_e1", ifA.FrameReady, 1'b0);
        cyc();
        checkVal("post_rst_e2", ifA.FrameReady, 1'b1);
        checkVal("post_rst_data", ifA.Frame, mk(500));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule

// File: doc/frame_store_ctrl.md
Name: frame_store_ctrl

Overview:
- Buffer controller between the trace frame assembler and the SPI packet packer.
- Stores 128-bit trace frames in a circular RAM and keeps one head frame pre-fetched into an output register.
- Presents Frame / FrameReady / FrameNext / FramesCnt to the SPI packer, and tracks frames dropped on overflow.
- All logic is clocked by clk; rst is asynchronous, active-high.

Parameters:
- BUFFLENLOG2, 9, log2 of RAM depth. Total capacity is 2^BUFFLENLOG2-1 frames (MAXCNT).
- LOSTW, 16, width of the lost-frame counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- WrFrame  in  128  frame from the assembler.
- WrValid  in  1  single-cycle write strobe for WrFrame.
- Frame  out  128  head frame, valid while FrameReady=1.
- FrameReady  out  1  head frame available.
- FrameNext  in  1  single-cycle pulse: head frame consumed.
- FramesCnt  out  BUFFLENLOG2  frames held (RAM plus head register).
- Flush  in  1  single-cycle pulse: discard all stored frames.
- Overflow  out  1  sticky flag: at least one frame dropped.
- LostCnt  out  LOSTW  dropped-frame count, saturating.
- ClrStats  in  1  pulse: clear Overflow and LostCnt.

Behaviour:
- Reset values: Frame=0, FrameReady=0, FramesCnt=0, Overflow=0, LostCnt=0, wp=rp=0, state=S_EMPTY. Reset takes effect immediately, including mid-fetch.
- RAM is simple dual-port with 1-cycle registered read. Write pointer is wp, read pointer is rp, both BUFFLENLOG2 bits wide and wrapping modulo 2^BUFFLENLOG2.
- Write acceptance:
  - WrValid with FramesCnt<MAXCNT: write RAM[wp], then wp++.
  - WrValid with FramesCnt==MAXCNT: frame dropped; Overflow<=1; LostCnt++ (saturates at all-ones).
  - A same-cycle FrameNext does not free space for that write.
- Head state machine:
  - S_EMPTY: if wp!=rp, issue read at rp, rp++, go to S_FETCH.
  - S_FETCH: Frame<=RAM data, FrameReady<=1, go to S_HOLD.
  - S_HOLD: on FrameNext, FrameReady<=0. Then, if wp!=rp, issue read and rp++ in the same cycle and go to S_FETCH; else go to S_EMPTY. Without FrameNext, remain in S_HOLD with Frame stable.
  - FrameNext outside S_HOLD is ignored and does not change FramesCnt.
- Latency:
  - Into an empty store: FrameReady rises on the 2nd rising edge after the edge that accepts the write.
  - Back-to-back consume: FrameReady is low for exactly 1 cycle after FrameNext.
- FramesCnt: +1 on accepted write, -1 on valid FrameNext (in S_HOLD), unchanged when both occur in the same cycle. Never wraps; the write gate guarantees count≤MAXCNT, so the pointers never alias.
- Flush (highest priority after rst):
  - Next cycle: wp=rp=0, FramesCnt=0, FrameReady=0, state=S_EMPTY.
  - Any in-flight read is discarded.
  - A WrValid in the flush cycle is discarded and not counted as lost.
  - A FrameNext in the flush cycle is ignored.
- ClrStats: Overflow<=0, LostCnt<=0. If a drop occurs in the same cycle, the drop wins: Overflow=1, LostCnt=1.
- Frame must not change while FrameReady=1.

Decomposition:
- Package frame_store_pkg:
  - state encoding S_EMPTY / S_FETCH / S_HOLD;
  - FRAMEW=128;
  - MAXCNT function of BUFFLENLOG2.
- Sub-module frame_ram: parameterised simple dual-port RAM (write port plus registered-read port) for BRAM inference. The controller holds pointers, count, FSM and statistics.

Test Plan:
- Single write of frame 0x0123…EF into an empty store → FrameReady=1 two edges later, Frame=0x0123…EF, FramesCnt=1; FrameNext → FrameReady=0 next cycle, FramesCnt=0, state S_EMPTY.
- BUFFLENLOG2=4: write 20 frames, no consumption → FramesCnt=15, Overflow=1, LostCnt=5. Then drain all 15 → order matches the first 15 written, FramesCnt ends at 0.
- Continuous WrValid together with FrameNext each time FrameReady=1, run past 3 pointer wraps (BUFFLENLOG2=4) → data order preserved, no loss, FramesCnt never exceeds 2.
- Same-cycle WrValid and FrameNext with FramesCnt=5 → FramesCnt stays 5.
- Flush with FramesCnt=7 and a simultaneous WrValid → next cycle FramesCnt=0, FrameReady=0, LostCnt unchanged; next write appears after 2 edges.
- LOSTW=2, 6 drops → LostCnt saturates at 3. ClrStats in the same cycle as a further drop → Overflow=1, LostCnt=1. Assert rst during S_FETCH → all outputs return to reset values immediately.
